// File: rtl/lcd_status_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_status_display_pkg
// Description : HD44780 command bytes, FSM state codes and status-field text.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_status_display_pkg;

    localparam logic [7:0] c_cmd_func_set = 8'h38;
    localparam logic [7:0] c_cmd_disp_on  = 8'h0C;
    localparam logic [7:0] c_cmd_clear    = 8'h01;
    localparam logic [7:0] c_cmd_entry    = 8'h06;
    localparam logic [7:0] c_cmd_row0     = 8'h80;
    localparam logic [7:0] c_cmd_row1     = 8'hC0;

    localparam logic [7:0] c_asc_space = 8'h20;
    localparam logic [7:0] c_asc_zero  = 8'h30;
    localparam logic [7:0] c_asc_colon = 8'h3A;
    localparam logic [7:0] c_asc_c     = 8'h43;
    localparam logic [7:0] c_asc_k     = 8'h4B;
    localparam logic [7:0] c_asc_l     = 8'h4C;
    localparam logic [7:0] c_asc_o     = 8'h4F;
    localparam logic [7:0] c_asc_w     = 8'h57;

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_init     = 4'd1;
    localparam logic [3:0] c_st_wait_clr = 4'd2;
    localparam logic [3:0] c_st_init2    = 4'd3;
    localparam logic [3:0] c_st_addr0    = 4'd4;
    localparam logic [3:0] c_st_row0     = 4'd5;
    localparam logic [3:0] c_st_addr1    = 4'd6;
    localparam logic [3:0] c_st_row1     = 4'd7;
    localparam logic [3:0] c_st_done     = 4'd8;
    localparam logic [3:0] c_st_watch    = 4'd9;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? (c_asc_zero + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Each channel owns an 8-character field: "Ck:" + "OK "/"LOW" + hex + ' '.
    function automatic logic [7:0] field_char(input logic [15:0] snap, input logic row,
                                              input logic [3:0] col, input int n_ch);
        logic [1:0] k;
        logic [3:0] nib;
        logic [7:0] ch;
        k   = {row, col[3]};
        nib = snap[{k, 2'b00} +: 4];
        case (col[2:0])
            3'd0:    ch = c_asc_c;
            3'd1:    ch = c_asc_zero + {6'h0, k};
            3'd2:    ch = c_asc_colon;
            3'd3:    ch = nib[0] ? c_asc_o : c_asc_l;
            3'd4:    ch = nib[0] ? c_asc_k : c_asc_o;
            3'd5:    ch = nib[0] ? c_asc_space : c_asc_w;
            3'd6:    ch = hex_ascii(nib);
            default: ch = c_asc_space;
        endcase
        if (int'(k) >= n_ch) ch = c_asc_space;
        return ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_byte_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_byte_writer
// Description : Writes one LCD byte as a SETUP / PULSE / HOLD slot.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_byte_writer #(
    parameter int COUNT_MAX = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] byte_in,
    output logic       rs,
    output logic [7:0] data,
    output logic       enable,
    output logic       done,
    output logic       busy
);

    localparam int CNT_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(COUNT_MAX - 1);

    localparam logic [1:0] c_ph_idle  = 2'd0;
    localparam logic [1:0] c_ph_setup = 2'd1;
    localparam logic [1:0] c_ph_pulse = 2'd2;
    localparam logic [1:0] c_ph_hold  = 2'd3;

    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_cnt;

    assign done = (r_phase == c_ph_hold) && (r_cnt == c_cnt_last);
    assign busy = (r_phase != c_ph_idle);

    // A start coinciding with done begins the next slot with no idle gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= c_ph_idle;
            r_cnt   <= '0;
            rs      <= 1'b0;
            data    <= 8'h00;
            enable  <= 1'b0;
        end else if (start && (!busy || done)) begin
            r_phase <= c_ph_setup;
            r_cnt   <= '0;
            rs      <= rs_in;
            data    <= byte_in;
            enable  <= 1'b0;
        end else if (busy) begin
            if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
                case (r_phase)
                    c_ph_setup: begin r_phase <= c_ph_pulse; enable <= 1'b1; end
                    c_ph_pulse: begin r_phase <= c_ph_hold;  enable <= 1'b0; end
                    default:          r_phase <= c_ph_idle;
                endcase
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_status_display.sv
`default_nettype none
// ============================================================================
// Module      : lcd_status_display
// Description : HD44780 16x2 status display; redraws when any channel changes.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_status_display
    import lcd_status_display_pkg::*;
#(
    parameter int COUNT_MAX    = 20,
    parameter int CLEAR_CYCLES = 100_000,
    parameter int N_CH         = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready_i,
    input  logic [4*N_CH-1:0] status_i,
    output logic              rs,
    output logic              rw,
    output logic              enable,
    output logic [7:0]        data,
    output logic              busy_o,
    output logic              frame_done_o
);

    generate
        if (N_CH < 1 || N_CH > 4) begin : g_bad_n_ch
            $error("lcd_status_display: N_CH must be 1..4");
        end
    endgenerate

    localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
    localparam logic [CLR_W-1:0] c_clr_last = CLR_W'(CLEAR_CYCLES - 1);

    logic [3:0]        r_state;
    logic [4:0]        r_idx;
    logic [CLR_W-1:0]  r_clr_cnt;
    logic [4*N_CH-1:0] r_snap;
    logic [15:0]       w_snap16;
    logic              w_write;
    logic              w_rs;
    logic [7:0]        w_byte;
    logic              w_launch;
    logic              w_wr_done;
    logic              w_wr_busy;

    assign w_snap16 = 16'(r_snap);
    assign rw       = 1'b0;
    assign busy_o   = (r_state != c_st_idle) && (r_state != c_st_watch);
    assign w_launch = w_write && (!w_wr_busy || w_wr_done);

    always_comb begin
        w_write = 1'b0;
        w_rs    = 1'b0;
        w_byte  = c_cmd_func_set;
        case (r_state)
            c_st_init: begin
                w_write = 1'b1;
                w_byte  = (r_idx == 5'd0) ? c_cmd_func_set :
                          (r_idx == 5'd1) ? c_cmd_disp_on  : c_cmd_clear;
            end
            c_st_init2: begin w_write = 1'b1; w_byte = c_cmd_entry; end
            c_st_addr0: begin w_write = 1'b1; w_byte = c_cmd_row0;  end
            c_st_addr1: begin w_write = 1'b1; w_byte = c_cmd_row1;  end
            c_st_row0: begin
                w_write = 1'b1;
                w_rs    = 1'b1;
                w_byte  = field_char(w_snap16, 1'b0, r_idx[3:0], N_CH);
            end
            c_st_row1: begin
                w_write = (r_idx != 5'd16);
                w_rs    = 1'b1;
                w_byte  = field_char(w_snap16, 1'b1, r_idx[3:0], N_CH);
            end
            default: ;
        endcase
    end

    // r_idx/state always point at the next byte to launch; a launch advances them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_idx        <= '0;
            r_clr_cnt    <= '0;
            r_snap       <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_idx <= '0;
                    if (ready_i) r_state <= c_st_init;
                end
                c_st_init: if (w_launch) begin
                    if (r_idx == 5'd2) begin
                        r_state   <= c_st_wait_clr;
                        r_idx     <= '0;
                        r_clr_cnt <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                // Counting includes the clear slot's final cycle, so INIT2
                // launches exactly CLEAR_CYCLES cycles after that slot ends.
                c_st_wait_clr: if (!w_wr_busy || w_wr_done) begin
                    if (r_clr_cnt == c_clr_last) r_state <= c_st_init2;
                    else                         r_clr_cnt <= r_clr_cnt + 1'b1;
                end
                c_st_init2: if (w_launch) r_state <= c_st_addr0;
                c_st_addr0: if (w_launch) begin
                    r_snap  <= status_i;
                    r_state <= c_st_row0;
                    r_idx   <= '0;
                end
                c_st_row0: if (w_launch) begin
                    if (r_idx == 5'd15) begin
                        r_state <= c_st_addr1;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_st_addr1: if (w_launch) begin
                    r_state <= c_st_row1;
                    r_idx   <= '0;
                end
                c_st_row1: begin
                    if (r_idx == 5'd16) begin
                        if (w_wr_done) begin
                            r_state      <= c_st_done;
                            r_idx        <= '0;
                            frame_done_o <= 1'b1;
                        end
                    end else if (w_launch) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                c_st_done:  r_state <= c_st_watch;
                c_st_watch: if (status_i != r_snap) r_state <= c_st_addr0;
                default:    r_state <= c_st_idle;
            endcase
        end
    end

    lcd_byte_writer #(
        .COUNT_MAX (COUNT_MAX)
    ) u_writer (
        .clk     (clk),
        .reset   (reset),
        .start   (w_launch),
        .rs_in   (w_rs),
        .byte_in (w_byte),
        .rs      (rs),
        .data    (data),
        .enable  (enable),
        .done    (w_wr_done),
        .busy    (w_wr_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_lcd_status_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_status_display
// Description : Directed bench for lcd_status_display (N_CH=2 and N_CH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_status_display;

    localparam int c_cm = 4;
    localparam int c_cw = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready2 = 1'b0, ready4 = 1'b0;
    logic [7:0]  st2 = 8'h00;
    logic [15:0] st4 = 16'h0000;
    logic        rs2, rw2, en2, busy2, fd2;
    logic        rs4, rw4, en4, busy4, fd4;
    logic [7:0]  d2, d4;

    always #5 clk = ~clk;

    lcd_status_display #(.COUNT_MAX(c_cm), .CLEAR_CYCLES(c_cw), .N_CH(2)) u_dut2 (
        .clk(clk), .reset(reset), .ready_i(ready2), .status_i(st2),
        .rs(rs2), .rw(rw2), .enable(en2), .data(d2), .busy_o(busy2), .frame_done_o(fd2));

    lcd_status_display #(.COUNT_MAX(c_cm), .CLEAR_CYCLES(c_cw), .N_CH(4)) u_dut4 (
        .clk(clk), .reset(reset), .ready_i(ready4), .status_i(st4),
        .rs(rs4), .rw(rw4), .enable(en4), .data(d4), .busy_o(busy4), .frame_done_o(fd4));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitors: capture {rs,data} at each enable rise and record event cycles.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] q2[$], q4[$];
    int ecyc2[$];
    int fdh2 = 0, fdcyc2 = 0, brise2 = 0, nbr2 = 0, fdh4 = 0;
    logic pen2 = 1'b0, pb2 = 1'b0, pen4 = 1'b0;

    always @(negedge clk) begin
        if (en2 && !pen2) begin q2.push_back({rs2, d2}); ecyc2.push_back(cyc); end
        if (busy2 && !pb2) begin brise2 = cyc; nbr2++; end
        if (fd2) begin fdh2++; fdcyc2 = cyc; end
        pen2 = en2;
        pb2  = busy2;
    end

    always @(negedge clk) begin
        if (en4 && !pen4) q4.push_back({rs4, d4});
        if (fd4) fdh4++;
        pen4 = en4;
    end

    function automatic logic [8:0] qbyte(input int which, input int idx);
        if (which == 4) return (idx < q4.size()) ? q4[idx] : 9'h1FF;
        return (idx < q2.size()) ? q2[idx] : 9'h1FF;
    endfunction

    task automatic check_str(input string tag, input int which, input int start, input string s);
        for (int i = 0; i < s.len(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(qbyte(which, start + i)), 32'({1'b1, s[i]}));
    endtask

    task automatic wait_frames2(input int target, input string tag);
        int n = 0;
        while (fdh2 < target && n < 3000) begin @(negedge clk); n++; end
        check(tag, fdh2, target);
    endtask

    initial begin
        int b0, f0, n;
        repeat (3) @(negedge clk);
        check("rst_rs", rs2, 0);
        check("rst_rw", rw2, 0);
        check("rst_enable", en2, 0);
        check("rst_data", d2, 0);
        check("rst_busy", busy2, 0);
        check("rst_frame_done", fd2, 0);

        // ready_i held low: nothing may start
        reset = 1'b0;
        b0 = q2.size();
        n  = nbr2;
        repeat (1000) @(negedge clk);
        check("idle_en_rises", q2.size() - b0, 0);
        check("idle_busy_rises", nbr2 - n, 0);

        // power-up frame
        b0 = q2.size();
        f0 = fdh2;
        ready2 = 1'b1;
        wait_frames2(f0 + 1, "pu_frame_wait");
        ready2 = 1'b0;
        check("pu_nbytes", q2.size() - b0, 38);
        check("pu_b0", qbyte(2, b0 + 0), 9'h038);
        check("pu_b1", qbyte(2, b0 + 1), 9'h00C);
        check("pu_b2", qbyte(2, b0 + 2), 9'h001);
        check("pu_b3", qbyte(2, b0 + 3), 9'h006);
        check("pu_b4", qbyte(2, b0 + 4), 9'h080);
        check_str("pu_row0", 2, b0 + 5, "C0:LOW0 C1:LOW0 ");
        check("pu_b21", qbyte(2, b0 + 21), 9'h0C0);
        check_str("pu_row1", 2, b0 + 22, "                ");
        check("pu_first_enable", (b0 < ecyc2.size()) ? ecyc2[b0] - brise2 : -1, c_cm + 1);
        check("pu_frame_time", fdcyc2 - brise2, 38 * 3 * c_cm + c_cw + 1);
        @(negedge clk);
        check("pu_done_width", fdh2, f0 + 1);
        check("pu_watch_busy", busy2, 0);

        // status change seen in WATCH: refresh frame, no init bytes
        repeat (5) @(negedge clk);
        b0 = q2.size();
        f0 = fdh2;
        st2 = 8'h31;
        wait_frames2(f0 + 1, "chg_frame_wait");
        check("chg_nbytes", q2.size() - b0, 34);
        check("chg_b0", qbyte(2, b0), 9'h080);
        check_str("chg_row0", 2, b0 + 1, "C0:OK 1 C1:OK 3 ");
        check("chg_b17", qbyte(2, b0 + 17), 9'h0C0);
        check("chg_frame_time", fdcyc2 - brise2, 34 * 3 * c_cm + 1);

        // change during ROW1, plus ready_i pulses mid-frame
        repeat (3) @(negedge clk);
        b0 = q2.size();
        f0 = fdh2;
        st2 = 8'h00;
        n = 0;
        while (q2.size() < b0 + 22 && n < 2000) begin @(negedge clk); n++; end
        check("mid_reach_row1", q2.size() >= b0 + 22, 1);
        ready2 = 1'b1;
        repeat (3) @(negedge clk);
        ready2 = 1'b0;
        st2 = 8'h01;
        wait_frames2(f0 + 2, "mid_frames_wait");
        repeat (600) @(negedge clk);
        check("mid_frame_count", fdh2 - f0, 2);
        check("mid_nbytes", q2.size() - b0, 68);
        check_str("mid_old_row0", 2, b0 + 1, "C0:LOW0 C1:LOW0 ");
        check("mid_new_b0", qbyte(2, b0 + 34), 9'h080);
        check_str("mid_new_row0", 2, b0 + 35, "C0:OK 1 C1:LOW0 ");

        // reset while enable is high mid-frame
        b0 = q2.size();
        st2 = 8'h22;
        n = 0;
        while (!(en2 && q2.size() >= b0 + 10) && n < 2000) begin @(negedge clk); n++; end
        check("rstmid_en_high", en2, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_enable", en2, 0);
        check("rstmid_data", d2, 0);
        check("rstmid_busy", busy2, 0);
        check("rstmid_rs", rs2, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        b0 = q2.size();
        f0 = fdh2;
        ready2 = 1'b1;
        wait_frames2(f0 + 1, "restart_frame_wait");
        ready2 = 1'b0;
        check("restart_b0", qbyte(2, b0), 9'h038);
        check_str("restart_row0", 2, b0 + 5, "C0:LOW2 C1:LOW2 ");
        check("restart_frame_time", fdcyc2 - brise2, 38 * 3 * c_cm + c_cw + 1);

        // four channels, hex digits above 9
        b0 = q4.size();
        f0 = fdh4;
        st4 = 16'hFA50;
        ready4 = 1'b1;
        n = 0;
        while (fdh4 < f0 + 1 && n < 3000) begin @(negedge clk); n++; end
        ready4 = 1'b0;
        check("n4_frame_count", fdh4 - f0, 1);
        check("n4_nbytes", q4.size() - b0, 38);
        check_str("n4_row0", 4, b0 + 5, "C0:LOW0 C1:OK 5 ");
        check("n4_b21", qbyte(4, b0 + 21), 9'h0C0);
        check_str("n4_row1", 4, b0 + 22, "C2:LOWA C3:OK F ");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
